// File: rtl/shared_adder_arbiter.sv
// -----------------------------------------------------------------------------
// shared_adder_arbiter
//
// Purpose:
//   Two requesters share one ripple-carry adder (RCA_nbit). A three-state
//   controller (IDLE -> EXEC -> DONE -> IDLE) does the following:
//     - accepts one request in IDLE,
//     - captures the winner's operands,
//     - registers the adder result at the end of EXEC,
//     - pulses the owner's done line during DONE.
//   When both requesters are high on the same edge, the arbiter alternates
//   between them (round-robin).
//
// Optional feature:
//   SHARED_ADDER_OVF_EN - when defined, adds output ovf. It is a registered
//   two's-complement signed-overflow flag that updates together with sum.
//
// Ports:
//   clk           in   single clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   req0 / req1   in   request lines, held high until the matching done
//   a0, b0 / a1, b1  in  N-bit operands, stable while the request is high
//   cin0 / cin1   in   carry-in, stable while the request is high
//   busy          out  high whenever the controller is not in IDLE
//   done0 / done1 out  one-cycle completion pulse for the owning requester
//   sum           out  registered N-bit result of the last completed operation
//   cout          out  registered carry-out of the last completed operation
//   ovf           out  (SHARED_ADDER_OVF_EN only) registered signed overflow
//
// This file also contains RCA_nbit, a plain n-bit ripple-carry adder.
// -----------------------------------------------------------------------------

module RCA_nbit #(
    parameter int n = 4
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         cin,
    output logic [n-1:0] sum,
    output logic         cout
);

    logic [n:0] carry;

    assign carry[0] = cin;

    // One full adder per bit; the carry ripples from bit 0 upward.
    for (genvar i = 0; i < n; i++) begin : gFullAdder
        assign sum[i]     = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[n];

endmodule

module shared_adder_arbiter #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0,
    input  logic [N-1:0] a0,
    input  logic [N-1:0] b0,
    input  logic         cin0,
    input  logic         req1,
    input  logic [N-1:0] a1,
    input  logic [N-1:0] b1,
    input  logic         cin1,
    output logic         busy,
    output logic         done0,
    output logic         done1,
    output logic [N-1:0] sum,
    output logic         cout
`ifdef SHARED_ADDER_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]   state_q, state_d;
    logic [N-1:0] opA_q;
    logic [N-1:0] opB_q;
    logic         opCin_q;
    logic         owner_q;
    logic         lastGrant_q;
    logic [N-1:0] sum_q;
    logic         cout_q;

    logic         anyReq;
    logic         grantSel;
    logic [N-1:0] adderSum;
    logic         adderCout;

    // The single shared adder always works on the captured operands.
    RCA_nbit #(
        .n(N)
    ) uAdder (
        .a   (opA_q),
        .b   (opB_q),
        .cin (opCin_q),
        .sum (adderSum),
        .cout(adderCout)
    );

    // On a tie, grant the requester that did not win last time. Otherwise
    // grant whichever one is asking.
    always_comb begin
        anyReq   = req0 | req1;
        grantSel = 1'b0;
        if (req0 && req1) begin
            grantSel = ~lastGrant_q;
        end else if (req1) begin
            grantSel = 1'b1;
        end
    end

    // Next-state logic. Requests are only considered in IDLE, and the other
    // transitions are unconditional, so an operation takes exactly three
    // cycles.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (anyReq) state_d = EXEC;
            EXEC:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the winner's operands at the acceptance edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opA_q       <= '0;
            opB_q       <= '0;
            opCin_q     <= 1'b0;
            owner_q     <= 1'b0;
            lastGrant_q <= 1'b1;
        end else if (state_q == IDLE && anyReq) begin
            opA_q       <= grantSel ? a1 : a0;
            opB_q       <= grantSel ? b1 : b0;
            opCin_q     <= grantSel ? cin1 : cin0;
            owner_q     <= grantSel;
            lastGrant_q <= grantSel;
        end
    end

    // Register the adder result at the EXEC->DONE edge. The result then holds
    // until the next completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (state_q == EXEC) begin
            sum_q  <= adderSum;
            cout_q <= adderCout;
        end
    end

`ifdef SHARED_ADDER_OVF_EN
    logic ovf_q;

    // Signed overflow occurs when both operands have the same sign and the
    // sum's sign differs from it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (state_q == EXEC) begin
            ovf_q <= (opA_q[N-1] == opB_q[N-1]) && (adderSum[N-1] != opA_q[N-1]);
        end
    end

    assign ovf = ovf_q;
`endif

    assign busy  = (state_q != IDLE);
    assign done0 = (state_q == DONE) && !owner_q;
    assign done1 = (state_q == DONE) && owner_q;
    assign sum   = sum_q;
    assign cout  = cout_q;

endmodule
